// File: rtl/msf_iq_load_scheduler.sv
// -----------------------------------------------------------------------------
// msf_iq_load_scheduler
//
// Sequencer for the shared IQ averager. One averager is time-multiplexed
// between the I and Q streams: after each MSF carrier pulse a phase counter
// runs, and load_val strobes are issued when the phase matches i_offset
// (sel_q=0) or q_offset (sel_q=1). Averaging windows of number_msf_periods
// carrier periods are framed and re-aligned on the rising edge of
// one_sec_marker. A watchdog on the phase counter declares carrier loss.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   enable              run enable; low forces IDLE on the next cycle
//   msf_carrier_pulse   one-cycle strobe, once per carrier period
//   one_sec_marker      second marker level; the rising edge is the event
//   number_msf_periods  carrier periods per window (0 = windows never end)
//   i_offset            phase at which the I load is requested
//   q_offset            phase at which the Q load is requested
//   load_val            one-cycle load strobe to the averager
//   sel_q               amplitude select for load_val (0 = I, 1 = Q); holds
//   window_start        one-cycle pulse, a new window begins
//   window_end          one-cycle pulse, a window completed normally
//   window_abort        one-cycle pulse, a window was cut short by a resync
//   period_count        carrier periods elapsed in the current window
//   carrier_lost        high while in LOST
//   state               IDLE=0, ARM=1, RUN=2, LOST=3
//
// TIMEOUT must be representable in OFS_W bits.
// -----------------------------------------------------------------------------
module msf_iq_load_scheduler #(
  parameter int unsigned CNT_W   = 13,
  parameter int unsigned OFS_W   = 9,
  parameter int unsigned TIMEOUT = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             msf_carrier_pulse,
  input  logic             one_sec_marker,
  input  logic [CNT_W-1:0] number_msf_periods,
  input  logic [OFS_W-1:0] i_offset,
  input  logic [OFS_W-1:0] q_offset,
  output logic             load_val,
  output logic             sel_q,
  output logic             window_start,
  output logic             window_end,
  output logic             window_abort,
  output logic [CNT_W-1:0] period_count,
  output logic             carrier_lost,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_LOST = 2'd3
  } state_t;

  localparam logic [OFS_W-1:0] TMO = OFS_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [OFS_W-1:0]   phase_q, phase_d;
  logic               pend_q, pend_d;
  logic               marker_d;
  logic [CNT_W-1:0]   pcnt_d;
  logic               load_d, sel_d, ws_d, we_d, wa_d, lost_d;

  logic               rise;
  logic               i_hit, q_req, wrap;
  logic [CNT_W-1:0]   pc_inc;

  assign rise   = one_sec_marker & ~marker_d;
  assign pc_inc = period_count + CNT_W'(1);
  assign state  = state_q;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      pend_q       <= 1'b0;
      marker_d     <= 1'b0;
      period_count <= '0;
      load_val     <= 1'b0;
      sel_q        <= 1'b0;
      window_start <= 1'b0;
      window_end   <= 1'b0;
      window_abort <= 1'b0;
      carrier_lost <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      marker_d     <= one_sec_marker;
      period_count <= pcnt_d;
      load_val     <= load_d;
      sel_q        <= sel_d;
      window_start <= ws_d;
      window_end   <= we_d;
      window_abort <= wa_d;
      carrier_lost <= lost_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    pcnt_d  = period_count;
    load_d  = 1'b0;
    sel_d   = sel_q;
    ws_d    = 1'b0;
    we_d    = 1'b0;
    wa_d    = 1'b0;
    i_hit   = 1'b0;
    q_req   = 1'b0;
    wrap    = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      phase_d = '0;
      pend_d  = 1'b0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
        end

        S_ARM: begin
          if (rise) begin
            state_d = S_RUN;
            phase_d = '0;
            pcnt_d  = '0;
            ws_d    = 1'b1;
          end
        end

        S_RUN: begin
          // Load arbitration: I wins a tie; the Q request is parked in
          // pend_q and issued on the following cycle.
          i_hit = (phase_q == i_offset);
          q_req = (phase_q == q_offset) | pend_q;
          if (i_hit) begin
            load_d = 1'b1;
            sel_d  = 1'b0;
            pend_d = q_req;
          end else if (q_req) begin
            load_d = 1'b1;
            sel_d  = 1'b1;
            pend_d = 1'b0;
          end

          // Window framing: a completing carrier pulse takes precedence
          // over a coincident marker rise, so no abort is reported then.
          wrap = msf_carrier_pulse && (number_msf_periods != '0) &&
                 (pc_inc == number_msf_periods);
          if (wrap) begin
            pcnt_d = '0;
            we_d   = 1'b1;
            ws_d   = 1'b1;
          end else if (rise) begin
            pcnt_d = '0;
            wa_d   = 1'b1;
            ws_d   = 1'b1;
          end else if (msf_carrier_pulse) begin
            pcnt_d = pc_inc;
          end

          // Phase counter, saturating at the watchdog limit.
          if (msf_carrier_pulse || rise) begin
            phase_d = '0;
          end else if (phase_q != TMO) begin
            phase_d = phase_q + OFS_W'(1);
          end

          // Carrier loss is declared on the edge where the phase reaches
          // the limit; any load decided on that same edge is suppressed.
          if (phase_d == TMO) begin
            state_d = S_LOST;
            load_d  = 1'b0;
            sel_d   = sel_q;
            pend_d  = 1'b0;
          end
        end

        S_LOST: begin
          if (msf_carrier_pulse) begin
            state_d = S_ARM;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    lost_d = (state_d == S_LOST);
  end

endmodule
